// File: rtl/vga_pkg.sv
// Shared VGA timing record type and the standard mode constants used as defaults.
// Totals: 800x600@72 is 1040 x 666 at 50 MHz; 640x480@60 is 800 x 525 at 25 MHz.
package vga_pkg;
   typedef struct packed {
      int   active;
      int   fp;
      int   sync;
      int   bp;
      logic pol;
   } axis_timing_t;

   typedef struct packed {
      axis_timing_t h;
      axis_timing_t v;
      int           clk_div;
   } vga_timing_t;

   localparam vga_timing_t SVGA_800X600_72 = '{
      h: '{active: 800, fp: 56, sync: 120, bp: 64, pol: 1'b1},
      v: '{active: 600, fp: 37, sync: 6,   bp: 23, pol: 1'b1},
      clk_div: 1
   };

   localparam vga_timing_t VGA_640X480_60 = '{
      h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0},
      v: '{active: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b0},
      clk_div: 2
   };

   function automatic int axis_total(axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: mod-TOTAL counter advanced by step, with combinational wrap/active/sync decode.
// Decode is unregistered; the top registers it alongside the pixel coordinates.
module vga_axis_counter import vga_pkg::*; #(
   parameter int TOTAL  = axis_total(SVGA_800X600_72.h),
   parameter int ACTIVE = SVGA_800X600_72.h.active,
   parameter int FP     = SVGA_800X600_72.h.fp,
   parameter int SYNC   = SVGA_800X600_72.h.sync,
   parameter bit POL    = SVGA_800X600_72.h.pol
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     step,
   output logic [$clog2(TOTAL)-1:0] count,
   output logic                     wrap,
   output logic                     active,
   output logic                     sync
);
   localparam int W = $clog2(TOTAL);
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

   assign wrap   = step && (count == LAST);
   assign active = (count < ACT_END);
   assign sync   = (count >= SYNC_BEG && count < SYNC_END) ? POL : ~POL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (step) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank generator: divider -> H counter -> V counter; all outputs registered, one cycle behind the counters.
// enable=0 freezes divider, counters and outputs; pulses (VGA_CLK, line_start, frame_start) are suppressed.
module vga_timing_gen import vga_pkg::*; #(
   parameter int H_ACTIVE = SVGA_800X600_72.h.active,
   parameter int H_FP     = SVGA_800X600_72.h.fp,
   parameter int H_SYNC   = SVGA_800X600_72.h.sync,
   parameter int H_BP     = SVGA_800X600_72.h.bp,
   parameter int V_ACTIVE = SVGA_800X600_72.v.active,
   parameter int V_FP     = SVGA_800X600_72.v.fp,
   parameter int V_SYNC   = SVGA_800X600_72.v.sync,
   parameter int V_BP     = SVGA_800X600_72.v.bp,
   parameter bit HS_POL   = SVGA_800X600_72.h.pol,
   parameter bit VS_POL   = SVGA_800X600_72.v.pol,
   parameter int CLK_DIV  = SVGA_800X600_72.clk_div
) (
   input  logic                                           CLOCK_50,
   input  logic                                           RESET_N,
   input  logic                                           enable,
   output logic                                           VGA_HS,
   output logic                                           VGA_VS,
   output logic                                           VGA_BLANK_N,
   output logic                                           VGA_SYNC_N,
   output logic                                           VGA_CLK,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] pix_x,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] pix_y,
   output logic                                           line_start,
   output logic                                           frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $error("vga_timing_gen: every porch and sync width must be at least 1");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16 || H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_size
      $error("vga_timing_gen: CLK_DIV must be 1..16 and totals at most 4096");
   end

   logic [3:0]    div;
   logic          pe;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_wrap, h_act, h_sync;
   logic          v_wrap, v_act, v_sync;
   logic          at_col0, at_origin;

   assign pe = enable && (div == 4'd0);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         div <= 4'd0;
      end else if (enable) begin
         div <= (div == 4'(CLK_DIV - 1)) ? 4'd0 : div + 4'd1;
      end
   end

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POL(HS_POL)
   ) u_h (
      .clk(CLOCK_50), .rst_n(RESET_N), .step(pe),
      .count(h), .wrap(h_wrap), .active(h_act), .sync(h_sync)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POL(VS_POL)
   ) u_v (
      .clk(CLOCK_50), .rst_n(RESET_N), .step(h_wrap),
      .count(v), .wrap(v_wrap), .active(v_act), .sync(v_sync)
   );

   assign VGA_SYNC_N = 1'b0;

   // at_col0/at_origin remember that the counters currently sit at column 0 / pixel (0,0).
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         VGA_BLANK_N <= 1'b0;
         VGA_CLK     <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         at_col0     <= 1'b1;
         at_origin   <= 1'b1;
      end else begin
         VGA_CLK     <= pe;
         line_start  <= pe && at_col0;
         frame_start <= pe && at_origin;
         if (pe) begin
            at_col0     <= h_wrap;
            at_origin   <= v_wrap;
            pix_x       <= h;
            pix_y       <= v;
            VGA_BLANK_N <= h_act && v_act;
            VGA_HS      <= h_sync;
            VGA_VS      <= v_sync;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generators (default, default-H with short frame, 640-wide /2 active-low with short frame)
// checked every cycle against an arithmetic pixel-index model plus directed sync/freeze/reset/wrap steps.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam vga_timing_t C0 = SVGA_800X600_72;
   localparam vga_timing_t C1 = '{h: SVGA_800X600_72.h, v: '{5, 2, 3, 2, 1'b1}, clk_div: 1};
   localparam vga_timing_t C2 = '{h: VGA_640X480_60.h, v: '{4, 1, 2, 1, 1'b0}, clk_div: 2};
   localparam vga_timing_t CFG [3] = '{C0, C1, C2};

   typedef struct packed {
      logic        hs, vs, bl, sn, ck, ls, fs;
      logic [15:0] x, y;
   } obs_t;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst_n [3];
   logic en [3];

   logic hs0, vs0, bl0, sn0, ck0, ls0, fs0;
   logic hs1, vs1, bl1, sn1, ck1, ls1, fs1;
   logic hs2, vs2, bl2, sn2, ck2, ls2, fs2;
   logic [10:0] x0;
   logic [9:0]  y0;
   logic [10:0] x1;
   logic [3:0]  y1;
   logic [9:0]  x2;
   logic [2:0]  y2;

   vga_timing_gen d0 (
      .CLOCK_50(clk), .RESET_N(rst_n[0]), .enable(en[0]),
      .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bl0), .VGA_SYNC_N(sn0), .VGA_CLK(ck0),
      .pix_x(x0), .pix_y(y0), .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(C1.h.active), .H_FP(C1.h.fp), .H_SYNC(C1.h.sync), .H_BP(C1.h.bp),
      .V_ACTIVE(C1.v.active), .V_FP(C1.v.fp), .V_SYNC(C1.v.sync), .V_BP(C1.v.bp),
      .HS_POL(C1.h.pol), .VS_POL(C1.v.pol), .CLK_DIV(C1.clk_div)
   ) d1 (
      .CLOCK_50(clk), .RESET_N(rst_n[1]), .enable(en[1]),
      .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1), .VGA_CLK(ck1),
      .pix_x(x1), .pix_y(y1), .line_start(ls1), .frame_start(fs1)
   );

   vga_timing_gen #(
      .H_ACTIVE(C2.h.active), .H_FP(C2.h.fp), .H_SYNC(C2.h.sync), .H_BP(C2.h.bp),
      .V_ACTIVE(C2.v.active), .V_FP(C2.v.fp), .V_SYNC(C2.v.sync), .V_BP(C2.v.bp),
      .HS_POL(C2.h.pol), .VS_POL(C2.v.pol), .CLK_DIV(C2.clk_div)
   ) d2 (
      .CLOCK_50(clk), .RESET_N(rst_n[2]), .enable(en[2]),
      .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK_N(bl2), .VGA_SYNC_N(sn2), .VGA_CLK(ck2),
      .pix_x(x2), .pix_y(y2), .line_start(ls2), .frame_start(fs2)
   );

   obs_t dut_o [3];
   assign dut_o[0] = {hs0, vs0, bl0, sn0, ck0, ls0, fs0, 16'(x0), 16'(y0)};
   assign dut_o[1] = {hs1, vs1, bl1, sn1, ck1, ls1, fs1, 16'(x1), 16'(y1)};
   assign dut_o[2] = {hs2, vs2, bl2, sn2, ck2, ls2, fs2, 16'(x2), 16'(y2)};

   int     vectors = 0;
   int     miscompares = 0;
   longint cycle = 0;
   longint ec [3];
   longint pc [3];
   obs_t   exp_o [3];

   logic   prev_hs0 = 1'b0, prev_vs1 = 1'b0, prev_hs2 = 1'b1;
   int     hs_run0 = -1, vs_run1 = -1, hs_run2 = -1;
   longint last_ls0 = -1, last_fs2 = -1;
   bit     clean2 = 1'b0;

   function automatic obs_t reset_obs(vga_timing_t t);
      obs_t o = '0;
      o.hs = ~t.h.pol;
      o.vs = ~t.v.pol;
      return o;
   endfunction

   // Outputs expected for the p-th displayed pixel since reset, from raster arithmetic alone.
   function automatic obs_t pixel_obs(vga_timing_t t, longint p);
      obs_t   o = '0;
      longint ht = axis_total(t.h);
      longint vt = axis_total(t.v);
      longint q  = p % (ht * vt);
      longint h  = q % ht;
      longint v  = q / ht;
      o.x  = 16'(h);
      o.y  = 16'(v);
      o.bl = (h < t.h.active) && (v < t.v.active);
      o.hs = (h >= t.h.active + t.h.fp && h < t.h.active + t.h.fp + t.h.sync) ? t.h.pol : ~t.h.pol;
      o.vs = (v >= t.v.active + t.v.fp && v < t.v.active + t.v.fp + t.v.sync) ? t.v.pol : ~t.v.pol;
      o.ck = 1'b1;
      o.ls = (h == 0);
      o.fs = (q == 0);
      return o;
   endfunction

   task automatic model_reset(int i);
      ec[i] = 0;
      pc[i] = 0;
      exp_o[i] = reset_obs(CFG[i]);
   endtask

   task automatic model_edge(int i);
      if (!rst_n[i]) begin
         model_reset(i);
      end else if (en[i]) begin
         if (ec[i] % CFG[i].clk_div == 0) begin
            exp_o[i] = pixel_obs(CFG[i], pc[i]);
            pc[i]++;
         end else begin
            exp_o[i].ck = 1'b0; exp_o[i].ls = 1'b0; exp_o[i].fs = 1'b0;
         end
         ec[i]++;
      end else begin
         exp_o[i].ck = 1'b0; exp_o[i].ls = 1'b0; exp_o[i].fs = 1'b0;
      end
   endtask

   task automatic check(string tag, logic [63:0] got, logic [63:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
      if (miscompares > 50) begin
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $fatal(1, "FAIL too many miscompares, stopping");
      end
   endtask

   task automatic monitors();
      if (ls0) begin
         if (last_ls0 >= 0) check("d0.line_period", 64'(cycle - last_ls0), 64'd1040);
         last_ls0 = cycle;
      end
      if (hs0 && !prev_hs0) begin check("d0.hs_start_x", 64'(x0), 64'd856); hs_run0 = 0; end
      if (hs0 && hs_run0 >= 0) hs_run0++;
      if (!hs0 && prev_hs0 && hs_run0 >= 0) begin check("d0.hs_width", 64'(hs_run0), 64'd120); hs_run0 = -1; end
      prev_hs0 = hs0;

      if (vs1 && !prev_vs1) begin
         check("d1.vs_start_y", 64'(y1), 64'd7);
         check("d1.vs_start_x", 64'(x1), 64'd0);
         vs_run1 = 0;
      end
      if (vs1 && ck1 && vs_run1 >= 0) vs_run1++;
      if (!vs1 && prev_vs1 && vs_run1 >= 0) begin check("d1.vs_pixels", 64'(vs_run1), 64'd3120); vs_run1 = -1; end
      prev_vs1 = vs1;

      if (!hs2 && prev_hs2) begin check("d2.hs_start_x", 64'(x2), 64'd656); hs_run2 = 0; end
      if (!hs2 && ck2 && hs_run2 >= 0) hs_run2++;
      if (hs2 && !prev_hs2 && hs_run2 >= 0) begin check("d2.hs_width", 64'(hs_run2), 64'd96); hs_run2 = -1; end
      prev_hs2 = hs2;
      if (fs2) begin
         if (last_fs2 >= 0 && clean2) check("d2.frame_cycles", 64'(cycle - last_fs2), 64'd12800);
         last_fs2 = cycle;
         clean2 = 1'b1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      if (!en[2] || !rst_n[2]) clean2 = 1'b0;
      cycle++;
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("d%0d.outputs@%0d", i, cycle), 64'(dut_o[i]), 64'(exp_o[i]));
      monitors();
   endtask

   initial begin
      obs_t frz;
      int   k;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         en[i]    = 1'b0;
         model_reset(i);
      end
      repeat (3) cyc();
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      repeat (3) cyc();

      // Reset release: first pe shows pixel (0,0) with frame_start.
      for (int i = 0; i < 3; i++) en[i] = 1'b1;
      cyc();
      check("d0.first_frame_start", 64'(fs0), 64'd1);
      check("d0.first_line_start", 64'(ls0), 64'd1);
      check("d0.first_pix_x", 64'(x0), 64'd0);

      // Frame wrap on the short-frame instance.
      k = 0;
      while (k < 13000 && !(x1 == 11'd1039 && y1 == 4'd11)) begin cyc(); k++; end
      check("d1.reached_last_pixel", 64'(x1 == 11'd1039 && y1 == 4'd11), 64'd1);
      cyc();
      check("d1.wrap_x", 64'(x1), 64'd0);
      check("d1.wrap_y", 64'(y1), 64'd0);
      check("d1.wrap_pulses", 64'({ls1, fs1}), 64'd3);
      repeat (1000) cyc();

      // Random enable gating on the two smaller instances.
      for (int n = 0; n < 4000; n++) begin
         en[1] = ($urandom_range(0, 3) != 0);
         en[2] = ($urandom_range(0, 2) != 0);
         cyc();
      end
      en[1] = 1'b1;
      en[2] = 1'b1;

      // Freeze at the last active pixel, then resume.
      k = 0;
      while (k < 13000 && !(x1 == 11'd799 && y1 == 4'd4)) begin cyc(); k++; end
      check("d1.reached_799_4", 64'(x1 == 11'd799 && y1 == 4'd4), 64'd1);
      frz = dut_o[1];
      frz.ck = 1'b0; frz.ls = 1'b0; frz.fs = 1'b0;
      en[1] = 1'b0;
      repeat (37) begin
         cyc();
         check("d1.frozen", 64'(dut_o[1]), 64'(frz));
      end
      en[1] = 1'b1;
      cyc();
      check("d1.resume_x", 64'(x1), 64'd800);
      check("d1.resume_blank_n", 64'(bl1), 64'd0);

      // Asynchronous reset in the middle of the H sync pulse.
      k = 0;
      while (k < 1100 && x0 != 11'd900) begin cyc(); k++; end
      check("d0.reached_x900", 64'(x0), 64'd900);
      check("d0.hs_mid_pulse", 64'(hs0), 64'd1);
      #3 rst_n[0] = 1'b0;
      #1;
      check("d0.async_hs", 64'(hs0), 64'd0);
      check("d0.async_x", 64'(x0), 64'd0);
      model_reset(0);
      prev_hs0 = 1'b0;
      hs_run0 = -1;
      last_ls0 = -1;
      repeat (2) cyc();
      rst_n[0] = 1'b1;
      cyc();
      check("d0.restart_frame_start", 64'(fs0), 64'd1);
      check("d0.restart_x", 64'(x0), 64'd0);
      repeat (2200) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 56, H front porch pixels.
REQ-003 SHALL have parameter H_SYNC, 120, H sync pulse pixels.
REQ-004 SHALL have parameter H_BP, 64, H back porch pixels.
REQ-005 SHALL have parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 37, V front porch lines.
REQ-007 SHALL have parameter V_SYNC, 6, V sync pulse lines.
REQ-008 SHALL have parameter V_BP, 23, V back porch lines.
REQ-009 SHALL have parameter HS_POL, 1, HS active level (1 = active-high).
REQ-010 SHALL have parameter VS_POL, 1, VS active level.
REQ-011 SHALL have parameter CLK_DIV, 1, CLOCK_50 cycles per pixel (1..16).
REQ-012 SHALL have port CLOCK_50  in  1  sole clock.
REQ-013 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-014 SHALL have port enable  in  1  counters run when high, freeze when low.
REQ-015 SHALL have port VGA_HS  out  1  horizontal sync.
REQ-016 SHALL have port VGA_VS  out  1  vertical sync.
REQ-017 SHALL have port VGA_BLANK_N  out  1  high only in the active region.
REQ-018 SHALL have port VGA_SYNC_N  out  1  tied 0 (no sync-on-green).
REQ-019 SHALL have port VGA_CLK  out  1  DAC latch strobe, high for the first CLOCK_50 cycle of each pixel period.
REQ-020 SHALL have port pix_x  out  clog2(H_TOTAL)  current column.
REQ-021 SHALL have port pix_y  out  clog2(V_TOTAL)  current row.
REQ-022 SHALL have port line_start  out  1  one-cycle pulse at column 0.
REQ-023 SHALL have port frame_start  out  1  one-cycle pulse at column 0, row 0.

Function
REQ-024 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; defaults give 1040 x 666 (800x600@72 Hz at 50 MHz).
REQ-025 SHALL generate internal pixel enable pe from a mod-CLK_DIV divider counter; CLK_DIV=1 makes pe constant high; the divider advances only while enable=1.
REQ-026 SHALL increment h on each pe; h = H_TOTAL-1 wraps to 0 and increments v; v = V_TOTAL-1 on the same wrap returns to 0.
REQ-027 SHALL register all outputs: outputs reflect the counter state with exactly 1 CLOCK_50 cycle latency.
REQ-028 SHALL drive VGA_BLANK_N = 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-029 SHALL drive VGA_HS = HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; VGA_VS identically on v with V parameters and VS_POL.
REQ-030 SHALL output pix_x = h and pix_y = v in all regions; blanking is indicated only by VGA_BLANK_N.
REQ-031 SHALL pulse line_start for the single cycle after pe causes h to become 0; frame_start likewise when h and v both become 0.
REQ-032 SHALL, while enable=0, hold every output at its last value, emit no VGA_CLK, line_start or frame_start pulses, and resume from the same h/v.
REQ-033 SHALL be sized for totals up to 4096 x 4096; each porch and sync parameter SHALL be >= 1, checked by elaboration-time assertion.

Reset
REQ-034 SHALL, while RESET_N=0, set h=0, v=0, divider=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0, VGA_CLK=0, pix_x=0, pix_y=0, line_start=0, frame_start=0.
REQ-035 SHALL, after RESET_N rises mid-frame, restart at h=0, v=0 and pulse frame_start on the first pe.

Structure
REQ-036 SHALL place the default 800x600@72 and 640x480@60 timing constants, plus a timing-record typedef, in shared package vga_pkg.
REQ-037 SHALL instantiate one sub-module vga_axis_counter (parameters TOTAL, ACTIVE, FP, SYNC, POL; outputs count, wrap, active, sync), used once for H and once for V.

Verification
REQ-038 SHALL check a default-parameter reset release: the first frame_start occurs 1 cycle after the first pe, and 1040 cycles separate consecutive line_start pulses.
REQ-039 SHALL check default H sync: VGA_HS is high for exactly 120 pe, beginning at pix_x=856; VGA_VS is high for 6 lines beginning at pix_y=637.
REQ-040 SHALL check CLK_DIV=2, 640x480 (96/16/48, 2/10/33, POL=0): VGA_CLK at 25 MHz, VGA_HS low for 96 pixels, frame length 800*525*2 cycles.
REQ-041 SHALL check enable=0 held for 37 cycles at h=799, v=599: outputs are frozen with no pulses; on resume the next pe gives h=800 and VGA_BLANK_N=0.
REQ-042 SHALL check RESET_N asserted asynchronously mid-pulse at h=900: VGA_HS drops to inactive without a clock edge, and counting restarts at 0.
REQ-043 SHALL check the frame wrap at h=1039, v=665: on the next pe h=0, v=0, and line_start and frame_start are asserted in the same cycle.
